// File: rtl/pong_ctrl_regs_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : pong_ctrl_regs_if                                     |
// | Brief    : XB data-memory bus seen by the pong register block    |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
interface pong_ctrl_regs_if;
  logic       dm_sel;
  logic [7:0] ramadr;
  logic       ramwe;
  logic       ramre;
  logic [7:0] dbus_in;
  logic [7:0] dbus_out;
  logic       io_out_en;

  modport master (
    output dm_sel, ramadr, ramwe, ramre, dbus_in,
    input  dbus_out, io_out_en
  );

  modport slave (
    input  dm_sel, ramadr, ramwe, ramre, dbus_in,
    output dbus_out, io_out_en
  );
endinterface
`default_nettype wire

// File: rtl/pong_ctrl_regs.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : pong_ctrl_regs                                        |
// | Brief    : XB-bus paddle/control/score registers, pulses and POR |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module pong_ctrl_regs #(
  parameter int         NUM_PADDLES = 2,
  parameter logic [7:0] BASE_ADDR   = 8'hE0,
  parameter int         PAD_RST     = 100,
  parameter int         PULSE_LEN   = 10,
  parameter int         POR_WAIT    = 20,
  parameter int         POR_WIDTH   = 380,
  parameter int         SCORE_W     = 4
) (
  input  logic                           sys_clk,
  input  logic                           rst_clk,
  pong_ctrl_regs_if.slave                bus,
  input  logic [NUM_PADDLES-1:0]         point_evt_i,
  output logic [8*NUM_PADDLES-1:0]       pad_pos_o,
  output logic [SCORE_W*NUM_PADDLES-1:0] scores_o,
  output logic [1:0]                     ball_speed_o,
  output logic                           demo_mode_o,
  output logic                           serv_ball_o,
  output logic                           game_rst_o,
  output logic                           game_rst_n_o
);

  localparam logic [7:0] c_off_cr  = 8'(NUM_PADDLES);
  localparam logic [7:0] c_off_sr  = 8'(NUM_PADDLES + 1);
  localparam logic [7:0] c_off_sc  = 8'(NUM_PADDLES + 2);
  localparam logic [7:0] c_span    = 8'(2 * NUM_PADDLES + 2);
  localparam logic [7:0] c_pulse   = 8'(PULSE_LEN);
  localparam logic [7:0] c_pad_rst = 8'(PAD_RST);
  localparam int         c_por_w   = $clog2(POR_WAIT + POR_WIDTH + 1);
  localparam logic [c_por_w-1:0] c_por_init = c_por_w'(POR_WAIT + POR_WIDTH);
  localparam logic [c_por_w-1:0] c_por_low  = c_por_w'(POR_WIDTH);

  logic [7:0]         pad_q     [NUM_PADDLES];
  logic [7:0]         pad_d     [NUM_PADDLES];
  logic [SCORE_W-1:0] score_q   [NUM_PADDLES];
  logic [SCORE_W-1:0] score_d   [NUM_PADDLES];
  logic [1:0]         speed_q,     speed_d;
  logic               demo_q,      demo_d;
  logic [7:0]         serve_cnt_q, serve_cnt_d;
  logic [7:0]         grst_cnt_q,  grst_cnt_d;
  logic [c_por_w-1:0] por_cnt_q,   por_cnt_d;

  logic [7:0] offset;
  logic       hit;
  logic       wr_en;
  logic       rd_en;
  logic       cr_wr;
  logic       score_clr;
  logic       por_done;
  logic [7:0] rd_data;

  // Offset arithmetic wraps, so addresses below BASE_ADDR land far outside the span.
  assign offset = bus.ramadr - BASE_ADDR;
  assign hit    = (offset < c_span);
  assign wr_en  = bus.dm_sel & bus.ramwe & hit;
  assign rd_en  = bus.dm_sel & bus.ramre & hit;
  assign cr_wr  = wr_en & (offset == c_off_cr);

  assign serv_ball_o  = (serve_cnt_q != 8'd0);
  assign game_rst_o   = (grst_cnt_q  != 8'd0);
  assign por_done     = (por_cnt_q == '0);
  assign game_rst_n_o = !((por_cnt_q != '0) && (por_cnt_q <= c_por_low));
  assign ball_speed_o = speed_q;
  assign demo_mode_o  = demo_q;

  // The reset-strobe write itself also clears, so a point landing in that
  // cycle never shows up during the pulse.
  assign score_clr = game_rst_o | (cr_wr & bus.dbus_in[0]);

  always_comb begin
    for (int i = 0; i < NUM_PADDLES; i++) begin
      pad_d[i]   = pad_q[i];
      score_d[i] = score_q[i];
      if (wr_en && (offset == 8'(i))) begin
        pad_d[i] = bus.dbus_in;
      end
      if (score_clr) begin
        score_d[i] = '0;
      end else if (point_evt_i[i] && (score_q[i] != '1)) begin
        score_d[i] = score_q[i] + SCORE_W'(1);
      end
    end
  end

  always_comb begin
    speed_d     = speed_q;
    demo_d      = demo_q;
    serve_cnt_d = (serve_cnt_q != 8'd0) ? serve_cnt_q - 8'd1 : serve_cnt_q;
    grst_cnt_d  = (grst_cnt_q  != 8'd0) ? grst_cnt_q  - 8'd1 : grst_cnt_q;
    por_cnt_d   = (por_cnt_q != '0) ? por_cnt_q - c_por_w'(1) : por_cnt_q;
    if (cr_wr) begin
      speed_d = bus.dbus_in[3:2];
      demo_d  = bus.dbus_in[7];
      if (bus.dbus_in[1]) begin
        serve_cnt_d = c_pulse;
      end
      if (bus.dbus_in[0]) begin
        grst_cnt_d = c_pulse;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge rst_clk) begin
    if (rst_clk) begin
      for (int i = 0; i < NUM_PADDLES; i++) begin
        pad_q[i]   <= c_pad_rst;
        score_q[i] <= '0;
      end
      speed_q     <= 2'b01;
      demo_q      <= 1'b1;
      serve_cnt_q <= 8'd0;
      grst_cnt_q  <= 8'd0;
      por_cnt_q   <= c_por_init;
    end else begin
      pad_q       <= pad_d;
      score_q     <= score_d;
      speed_q     <= speed_d;
      demo_q      <= demo_d;
      serve_cnt_q <= serve_cnt_d;
      grst_cnt_q  <= grst_cnt_d;
      por_cnt_q   <= por_cnt_d;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    if (rd_en) begin
      if (offset == c_off_cr) begin
        rd_data = {demo_q, 3'b000, speed_q, 2'b00};
      end else if (offset == c_off_sr) begin
        rd_data = {demo_q, 4'b0000, por_done, game_rst_o, serv_ball_o};
      end else begin
        for (int i = 0; i < NUM_PADDLES; i++) begin
          if (offset == 8'(i)) begin
            rd_data = pad_q[i];
          end
          if (offset == (c_off_sc + 8'(i))) begin
            rd_data = 8'(score_q[i]);
          end
        end
      end
    end
  end

  assign bus.dbus_out  = rd_data;
  assign bus.io_out_en = rd_en;

  for (genvar gi = 0; gi < NUM_PADDLES; gi++) begin : g_out
    assign pad_pos_o[8*gi +: 8]            = pad_q[gi];
    assign scores_o[SCORE_W*gi +: SCORE_W] = score_q[gi];
  end

endmodule
`default_nettype wire
